alu_mem_arbiter: RTL and testbench
==================================

// Module: alu_mem_arbiter
// PURPOSE
//  Shares one simple_alu_memory datapath between two requesters (r0, r1).
//  - Round-robin arbitration.
//  - Latches the winner's operands and holds them stable for ALU_LAT cycles.
//  - Pulses the datapath write-enable so the result is stored at the requested address.
//  - Returns y/c to the winner over a valid/ready response channel.
//  Sits between the requesting control FSMs and the ALU+result-memory datapath.
// PARAMETERS
//  ALU_LAT  1  cycles operands are held before y/c are sampled (>=1)
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  r0_valid   in   1  requester 0 has an op
//  r0_ready   out  1  requester 0 op accepted this cycle
//  r0_a       in   2  operand A
//  r0_b       in   2  operand B
//  r0_op      in   2  ALU ctrl code
//  r0_addr    in   2  result-memory address
//  r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_addr  same as r0 for requester 1
//  rsp_valid  out  1  response available
//  rsp_ready  in   1  response consumer ready
//  rsp_id     out  1  requester owning response (0/1)
//  rsp_y      out  4  captured ALU result
//  rsp_c      out  1  captured ALU carry/flag
//  alu_a      out  2  to datapath A
//  alu_b      out  2  to datapath B
//  alu_ctrl   out  2  to datapath ctrl
//  alu_addr   out  2  to datapath addr
//  alu_we     out  1  to datapath we
//  alu_y      in   4  from datapath y
//  alu_c      in   1  from datapath c
//  busy       out  1  high in any state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE, last_grant=1 (so r0 wins first tie).
//  - All outputs 0: rsp_*, alu_*, busy, r*_ready.
//  States:
//  - IDLE: rX_ready combinational, asserted for exactly one requester:
//    * only one valid -> that one;
//    * both valid -> the one != last_grant.
//  - On valid&&ready edge: latch a/b/op/addr and id; last_grant<=id; cnt<=ALU_LAT; ->EXEC.
//  - EXEC: alu_a/b/ctrl/addr driven from latched regs (stable entire EXEC).
//    * cnt decrements each cycle.
//    * In the cycle with cnt==1: alu_we=1; at that edge capture alu_y->rsp_y, alu_c->rsp_c; ->RESP.
//  - RESP: rsp_valid=1, rsp_id/rsp_y/rsp_c stable until rsp_valid&&rsp_ready.
//    * On that handshake edge -> IDLE.
//    * No new request accepted in the same cycle.
//  Outside EXEC:
//  - alu_we=0.
//  - alu_a/b/ctrl/addr=0.
//  - r*_ready=0 in EXEC and RESP.
//  Latency: accept edge k -> EXEC for ALU_LAT cycles -> rsp_valid first high in cycle k+ALU_LAT+1.
//  - Throughput: one op per ALU_LAT+2 cycles with rsp_ready held high.
//  Fairness: back-to-back contention alternates r0,r1,r0,...; a lone requester may win repeatedly.
//  Operand changes on rX_* after acceptance have no effect (latched copy used).
//  rsp_ready high outside RESP is ignored.
//  rst_n low mid-EXEC/RESP: immediate return to reset values.
//  - In-flight op dropped, no response.
//  - alu_we deasserts immediately.
// TESTING  (bench stub: alu_y = alu_a+alu_b zero-extended, alu_c = alu_ctrl[0])
//  1. Reset: rst_n=0 for 3 cycles -> all outputs 0, busy=0.
//  2. r0 alone: a=2,b=1,op=00,addr=0, ALU_LAT=1, rsp_ready=1:
//     - accept at edge k; alu_we=1 in cycle k+1;
//     - rsp_valid=1 in cycle k+2 with rsp_id=0, rsp_y=3, rsp_c=0.
//  3. Both valid every cycle after reset:
//     - grant order r0,r1,r0,r1;
//     - r1 op a=1,b=2,op=01,addr=2 -> rsp_y=3, rsp_c=1, rsp_id=1.
//  4. Backpressure: rsp_ready=0 for 5 cycles in RESP:
//     - rsp_valid/y/c/id held;
//     - no ready to either requester;
//     - IDLE one edge after rsp_ready=1.
//  5. ALU_LAT=3: operands stable 3 EXEC cycles, alu_we high only in the 3rd;
//     - r0 changes a mid-EXEC -> rsp_y reflects latched value.
//  6. rst_n pulsed low in EXEC:
//     - alu_we drops asynchronously; no rsp_valid follows;
//     - next request after reset is accepted normally.

Source files
------------

// File: rtl/alu_mem_arbiter.sv
// Round-robin arbiter sharing one ALU + result-memory datapath between two requesters.
// The winner's operands are latched and held for ALU_LAT cycles, then y/c return over a valid/ready channel.
//
// state | meaning
// IDLE  | waiting for a request; ready offered to at most one requester
// EXEC  | latched operands driven to the datapath, down-counting to the write cycle
// RESP  | captured result presented until the consumer takes it
module alu_mem_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [1:0] r0_a,
    input  logic [1:0] r0_b,
    input  logic [1:0] r0_op,
    input  logic [1:0] r0_addr,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [1:0] r1_a,
    input  logic [1:0] r1_b,
    input  logic [1:0] r1_op,
    input  logic [1:0] r1_addr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_y,
    output logic       rsp_c,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_ctrl,
    output logic [1:0] alu_addr,
    output logic       alu_we,
    input  logic [3:0] alu_y,
    input  logic       alu_c,
    output logic       busy
);

    localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic [1:0]    a_q, b_q, op_q, addr_q;
    logic          id_q;
    logic          grant_vld, grant_id;
    logic          cnt_tc;

    assign cnt_tc = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            id_q       <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_c      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                id_q       <= grant_id;
                last_grant <= grant_id;
                cnt        <= CW'(ALU_LAT);
                a_q        <= grant_id ? r1_a    : r0_a;
                b_q        <= grant_id ? r1_b    : r0_b;
                op_q       <= grant_id ? r1_op   : r0_op;
                addr_q     <= grant_id ? r1_addr : r0_addr;
            end else if (state == EXEC) begin
                cnt <= cnt - CW'(1);
                // Terminal-count cycle: datapath result is valid alongside the write strobe.
                if (cnt_tc) begin
                    rsp_y  <= alu_y;
                    rsp_c  <= alu_c;
                    rsp_id <= id_q;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = '0;
        alu_addr  = '0;
        alu_we    = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (r0_valid && r1_valid) begin
                    grant_vld = 1'b1;
                    grant_id  = ~last_grant;
                end else if (r0_valid) begin
                    grant_vld = 1'b1;
                    grant_id  = 1'b0;
                end else if (r1_valid) begin
                    grant_vld = 1'b1;
                    grant_id  = 1'b1;
                end
                // Gated by rst_n so no requester sees ready while reset is held.
                r0_ready = grant_vld && !grant_id && rst_n;
                r1_ready = grant_vld &&  grant_id && rst_n;
                if (grant_vld) state_nxt = EXEC;
            end
            EXEC: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_ctrl = op_q;
                alu_addr = addr_q;
                alu_we   = cnt_tc;
                if (cnt_tc) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mem_arbiter.sv
// Directed bench for alu_mem_arbiter: one instance with ALU_LAT=1 and one with ALU_LAT=3 share stimulus,
// each held in reset while the other is exercised; responses are checked against a scoreboard queue.
module tb_alu_mem_arbiter;

    typedef struct packed {
        logic       id;
        logic [3:0] y;
        logic       c;
    } exp_t;

    logic       clk;
    logic       rst1_n, rst3_n;
    logic       r0_valid, r1_valid, rsp_ready;
    logic [1:0] r0_a, r0_b, r0_op, r0_addr;
    logic [1:0] r1_a, r1_b, r1_op, r1_addr;

    logic       d1_r0_ready, d1_r1_ready, d1_rsp_valid, d1_rsp_id, d1_rsp_c, d1_alu_we, d1_alu_c, d1_busy;
    logic [3:0] d1_rsp_y, d1_alu_y;
    logic [1:0] d1_alu_a, d1_alu_b, d1_alu_ctrl, d1_alu_addr;
    logic       d3_r0_ready, d3_r1_ready, d3_rsp_valid, d3_rsp_id, d3_rsp_c, d3_alu_we, d3_alu_c, d3_busy;
    logic [3:0] d3_rsp_y, d3_alu_y;
    logic [1:0] d3_alu_a, d3_alu_b, d3_alu_ctrl, d3_alu_addr;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t e;

    // Datapath stub: y = a + b zero-extended, c = ctrl[0]
    assign d1_alu_y = {2'b00, d1_alu_a} + {2'b00, d1_alu_b};
    assign d1_alu_c = d1_alu_ctrl[0];
    assign d3_alu_y = {2'b00, d3_alu_a} + {2'b00, d3_alu_b};
    assign d3_alu_c = d3_alu_ctrl[0];

    alu_mem_arbiter #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .r0_valid(r0_valid), .r0_ready(d1_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_addr(r0_addr),
        .r1_valid(r1_valid), .r1_ready(d1_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_addr(r1_addr),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d1_rsp_id), .rsp_y(d1_rsp_y), .rsp_c(d1_rsp_c),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_ctrl(d1_alu_ctrl), .alu_addr(d1_alu_addr), .alu_we(d1_alu_we),
        .alu_y(d1_alu_y), .alu_c(d1_alu_c), .busy(d1_busy)
    );

    alu_mem_arbiter #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .r0_valid(r0_valid), .r0_ready(d3_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_addr(r0_addr),
        .r1_valid(r1_valid), .r1_ready(d3_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_addr(r1_addr),
        .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d3_rsp_id), .rsp_y(d3_rsp_y), .rsp_c(d3_rsp_c),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_ctrl(d3_alu_ctrl), .alu_addr(d3_alu_addr), .alu_we(d3_alu_we),
        .alu_y(d3_alu_y), .alu_c(d3_alu_c), .busy(d3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic id, input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        exp_t r;
        r.id = id;
        r.y  = {2'b00, a} + {2'b00, b};
        r.c  = op[0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id, input logic [3:0] y, input logic c);
        exp_t x;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_sb_empty observed=response expected=none", tag);
        end else begin
            x = sb.pop_front();
            chk({tag, "_valid"}, {7'b0, v}, 8'h01);
            chk({tag, "_id"},    {7'b0, id}, {7'b0, x.id});
            chk({tag, "_y"},     {4'b0, y}, {4'b0, x.y});
            chk({tag, "_c"},     {7'b0, c}, {7'b0, x.c});
        end
    endtask

    initial begin
        rst1_n = 1'b0; rst3_n = 1'b0;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0; r0_addr = '0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0; r1_addr = '0;
        rsp_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_rsp", {4'b0, d1_rsp_valid, d1_rsp_id, d1_rsp_c, 1'b0}, 8'h00);
        chk("rst_rsp_y", {4'b0, d1_rsp_y}, 8'h00);
        chk("rst_alu", {d1_alu_a, d1_alu_b, d1_alu_ctrl, d1_alu_addr}, 8'h00);
        chk("rst_we_busy", {6'b0, d1_alu_we, d1_busy}, 8'h00);
        chk("rst_ready", {6'b0, d1_r0_ready, d1_r1_ready}, 8'h00);
        chk("rst_busy3", {7'b0, d3_busy}, 8'h00);
        rst1_n = 1'b1;

        // r0 alone, ALU_LAT=1
        r0_valid = 1'b1; r0_a = 2'd2; r0_b = 2'd1; r0_op = 2'b00; r0_addr = 2'd0;
        rsp_ready = 1'b1;
        #1;
        chk("solo_ready", {6'b0, d1_r0_ready, d1_r1_ready}, 8'h02);
        sb.push_back(model(1'b0, 2'd2, 2'd1, 2'b00));
        tick();
        r0_valid = 1'b0;
        chk("solo_exec", {d1_alu_we, d1_busy, d1_alu_a, d1_alu_b, d1_alu_addr}, {1'b1, 1'b1, 2'd2, 2'd1, 2'd0});
        chk("solo_novalid", {7'b0, d1_rsp_valid}, 8'h00);
        tick();
        check_rsp("solo_rsp", d1_rsp_valid, d1_rsp_id, d1_rsp_y, d1_rsp_c);
        tick();
        chk("solo_idle", {6'b0, d1_busy, d1_rsp_valid}, 8'h00);

        // Contention from reset: r0,r1,r0,r1
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        r0_valid = 1'b1; r0_a = 2'd3; r0_b = 2'd2; r0_op = 2'b10; r0_addr = 2'd1;
        r1_valid = 1'b1; r1_a = 2'd1; r1_b = 2'd2; r1_op = 2'b01; r1_addr = 2'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_grant%0d", i), {6'b0, d1_r0_ready, d1_r1_ready}, (i % 2 == 0) ? 8'h02 : 8'h01);
            if (i % 2 == 0) sb.push_back(model(1'b0, r0_a, r0_b, r0_op));
            else            sb.push_back(model(1'b1, r1_a, r1_b, r1_op));
            tick();
            chk($sformatf("rr_exec%0d", i), {5'b0, d1_alu_we, d1_alu_addr}, {5'b0, 1'b1, (i % 2 == 0) ? 2'd1 : 2'd2});
            tick();
            check_rsp($sformatf("rr_rsp%0d", i), d1_rsp_valid, d1_rsp_id, d1_rsp_y, d1_rsp_c);
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;

        // Backpressure in RESP
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_a = 2'd1; r0_b = 2'd1; r0_op = 2'b00; r0_addr = 2'd3;
        #1;
        chk("bp_ready", {6'b0, d1_r0_ready, d1_r1_ready}, 8'h02);
        sb.push_back(model(1'b0, 2'd1, 2'd1, 2'b00));
        tick();
        r0_valid = 1'b0; r1_valid = 1'b1;
        tick();
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {1'b0, d1_rsp_valid, d1_rsp_id, d1_rsp_y, d1_rsp_c},
                {1'b0, 1'b1, e.id, e.y, e.c});
            chk($sformatf("bp_noready%0d", i), {6'b0, d1_r0_ready, d1_r1_ready}, 8'h00);
            tick();
        end
        r1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("bp_still", {7'b0, d1_rsp_valid}, 8'h01);
        tick();
        chk("bp_idle", {6'b0, d1_busy, d1_rsp_valid}, 8'h00);

        // ALU_LAT=3 with operand change mid-EXEC
        rst1_n = 1'b0;
        rst3_n = 1'b1;
        r0_valid = 1'b1; r0_a = 2'd1; r0_b = 2'd2; r0_op = 2'b11; r0_addr = 2'd3;
        #1;
        chk("l3_ready", {6'b0, d3_r0_ready, d3_r1_ready}, 8'h02);
        sb.push_back(model(1'b0, 2'd1, 2'd2, 2'b11));
        tick();
        r0_valid = 1'b0; r0_a = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("l3_ops%0d", i), {d3_alu_a, d3_alu_b, d3_alu_ctrl, d3_alu_addr}, {2'd1, 2'd2, 2'b11, 2'd3});
            chk($sformatf("l3_we%0d", i), {6'b0, d3_alu_we, d3_rsp_valid}, (i == 2) ? 8'h02 : 8'h00);
            tick();
        end
        check_rsp("l3_rsp", d3_rsp_valid, d3_rsp_id, d3_rsp_y, d3_rsp_c);
        tick();
        chk("l3_idle", {7'b0, d3_busy}, 8'h00);

        // Reset pulse mid-EXEC
        rst3_n = 1'b0;
        rst1_n = 1'b1;
        r1_valid = 1'b1; r1_a = 2'd2; r1_b = 2'd2; r1_op = 2'b00; r1_addr = 2'd1;
        #1;
        chk("ar_ready", {6'b0, d1_r0_ready, d1_r1_ready}, 8'h01);
        tick();
        r1_valid = 1'b0;
        chk("ar_we_before", {7'b0, d1_alu_we}, 8'h01);
        #2;
        rst1_n = 1'b0;
        #1;
        chk("ar_we_async", {6'b0, d1_alu_we, d1_busy}, 8'h00);
        #2;
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ar_norsp%0d", i), {6'b0, d1_rsp_valid, d1_busy}, 8'h00);
        end
        r0_valid = 1'b1; r0_a = 2'd0; r0_b = 2'd1; r0_op = 2'b01; r0_addr = 2'd2;
        #1;
        chk("ar_next_ready", {6'b0, d1_r0_ready, d1_r1_ready}, 8'h02);
        sb.push_back(model(1'b0, 2'd0, 2'd1, 2'b01));
        tick();
        r0_valid = 1'b0;
        tick();
        check_rsp("ar_next_rsp", d1_rsp_valid, d1_rsp_id, d1_rsp_y, d1_rsp_c);
        tick();
        chk("ar_next_idle", {7'b0, d1_busy}, 8'h00);
        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
